// File: rtl/instr_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_ctrl
// Purpose  : Fetch sequencer for a combinational instruction memory. Owns the
//            PC, captures {pc,instr} into a 2-entry prefetch FIFO, and hands
//            entries to decode over valid/ready. Handles redirect with flush,
//            level halt requests and misaligned/out-of-range address faults.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_ctrl #(
   parameter int               WIDTH    = 32,
   parameter int               DEPTH    = 8,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic [WIDTH-1:0] imem_addr_o,
   input  logic [WIDTH-1:0] imem_data_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] out_instr_o,
   output logic [WIDTH-1:0] out_pc_o,
   input  logic             redirect_valid_i,
   input  logic [WIDTH-1:0] redirect_pc_i,
   input  logic             halt_req_i,
   output logic             fault_o,
   output logic [1:0]       state_o,
   output logic [WIDTH-1:0] fetch_cnt_o
);

   // First byte address past the end of the instruction memory.
   localparam logic [WIDTH-1:0] PC_LIMIT = WIDTH'(64'd4 << DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_FETCH  = 2'b01,
      ST_HALTED = 2'b10,
      ST_FAULT  = 2'b11
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] fifo_pc_q    [2];
   logic [WIDTH-1:0] fifo_instr_q [2];
   logic             rd_ptr_q;
   logic             wr_ptr_q;
   logic [1:0]       count_q;
   logic [WIDTH-1:0] fetch_cnt_q;

   logic w_pop;
   logic w_push;
   logic w_flush;
   logic w_push_ok;
   logic w_addr_bad;

   assign w_pop      = (count_q != 2'd0) && out_ready_i;
   // A full FIFO can still accept a push when its head leaves on the same edge.
   assign w_push_ok  = (count_q != 2'd2) || w_pop;
   assign w_addr_bad = (pc_q[1:0] != 2'b00) || (pc_q >= PC_LIMIT);

   // Next-state decode: redirect beats halt, halt beats the fault check,
   // and the fault check beats a push.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      w_push  = 1'b0;
      w_flush = 1'b0;
      case (state_q)
         ST_IDLE: begin
            state_d = ST_FETCH;
         end
         default: begin
            if (redirect_valid_i) begin
               w_flush = 1'b1;
               pc_d    = redirect_pc_i;
               state_d = halt_req_i ? ST_HALTED : ST_FETCH;
            end else begin
               case (state_q)
                  ST_FETCH: begin
                     if (halt_req_i) begin
                        state_d = ST_HALTED;
                     end else if (w_addr_bad) begin
                        state_d = ST_FAULT;
                     end else if (w_push_ok) begin
                        w_push = 1'b1;
                        pc_d   = pc_q + WIDTH'(4);
                     end
                  end
                  ST_HALTED: begin
                     if (!halt_req_i) begin
                        state_d = ST_FETCH;
                     end
                  end
                  default: begin
                     state_d = state_q;
                  end
               endcase
            end
         end
      endcase
   end

   // State and PC registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   // Prefetch FIFO; a flush discards everything, including a same-edge push.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            fifo_pc_q[i]    <= '0;
            fifo_instr_q[i] <= '0;
         end
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else if (w_flush) begin
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (w_push) begin
            fifo_pc_q[wr_ptr_q]    <= pc_q;
            fifo_instr_q[wr_ptr_q] <= imem_data_i;
            wr_ptr_q               <= ~wr_ptr_q;
         end
         if (w_pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         case ({w_push, w_pop})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Push counter; only reset clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt_q <= '0;
      end else if (w_push) begin
         fetch_cnt_q <= fetch_cnt_q + WIDTH'(1);
      end
   end

   assign imem_addr_o = pc_q;
   assign out_valid_o = (count_q != 2'd0);
   assign out_instr_o = fifo_instr_q[rd_ptr_q];
   assign out_pc_o    = fifo_pc_q[rd_ptr_q];
   assign fault_o     = (state_q == ST_FAULT);
   assign state_o     = state_q;
   assign fetch_cnt_o = fetch_cnt_q;

endmodule
`default_nettype wire
